// File: rtl/spi_slave.sv
// Byte-oriented SPI target: synchronises sck/ss/mosi onto sysclk and exchanges 8-bit frames
// in any CPOL/CPHA mode. Define SPI_SLAVE_LSB_FIRST_EN for LSB-first frames.
module spi_slave #(
  parameter int SYNC_STAGES = 2  // legal range 2..3
) (
  input  logic       sysclk,
  input  logic       nreset,
  input  logic       enable,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       sck,
  input  logic       ss,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data_reg,
  input  logic       tx_reg_we,
  output logic       tx_reg_empty,
  output logic [7:0] rx_data_reg,
  output logic       rx_data_ready,
  input  logic       rx_reg_re,
  input  logic       clear_error,
  output logic       rx_error,
  output logic       tx_underrun,
  output logic       frame_error,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_d1_q, sck_d1_d;
  logic                   ss_d1_q, ss_d1_d;
  logic [7:0]             tx_sr_q, tx_sr_d;
  logic [7:0]             rx_sr_q, rx_sr_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             hold_q, hold_d;
  logic                   empty_q, empty_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_ready_q, rx_ready_d;
  logic                   rx_err_q, rx_err_d;
  logic                   underrun_q, underrun_d;
  logic                   frame_err_q, frame_err_d;
  logic                   miso_q, miso_d;

  logic       sck_s, ss_s, mosi_s;
  logic       leading, trailing, sample_edge, shift_edge;
  logic       ss_fall, ss_rise;
  logic       load, byte_done;
  logic [7:0] rx_next, tx_shifted;
  logic       tx_out_bit;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Leading edge leaves the idle level, trailing edge returns to it.
  assign leading     = (sck_d1_q == cpol) && (sck_s != cpol);
  assign trailing    = (sck_d1_q != cpol) && (sck_s == cpol);
  assign sample_edge = cpha ? trailing : leading;
  assign shift_edge  = cpha ? leading : trailing;
  assign ss_fall     = ss_d1_q && !ss_s;
  assign ss_rise     = !ss_d1_q && ss_s;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign rx_next    = {mosi_s, rx_sr_q[7:1]};
  assign tx_shifted = {1'b0, tx_sr_q[7:1]};
  assign tx_out_bit = tx_sr_q[0];
`else
  assign rx_next    = {rx_sr_q[6:0], mosi_s};
  assign tx_shifted = {tx_sr_q[6:0], 1'b0};
  assign tx_out_bit = tx_sr_q[7];
`endif

  always_comb begin
    state_d     = state_q;
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sck_d1_d    = sck_s;
    ss_d1_d     = ss_s;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    bit_cnt_d   = bit_cnt_q;
    hold_d      = hold_q;
    empty_d     = empty_q;
    rx_data_d   = rx_data_q;
    rx_ready_d  = rx_ready_q;
    rx_err_d    = rx_err_q;
    underrun_d  = underrun_q;
    frame_err_d = frame_err_q;
    miso_d      = tx_out_bit;
    load        = 1'b0;
    byte_done   = 1'b0;

    // Clears are applied first so that any set event below wins.
    if (clear_error) begin
      rx_err_d    = 1'b0;
      underrun_d  = 1'b0;
      frame_err_d = 1'b0;
    end
    if (rx_reg_re) rx_ready_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable && ss_fall) begin
          state_d   = ACTIVE;
          bit_cnt_d = 3'd0;
          load      = 1'b1;
        end
      end
      ACTIVE: begin
        if (!enable || ss_rise) begin
          state_d = FLUSH;
        end else if (sample_edge) begin
          rx_sr_d   = rx_next;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_done = 1'b1;
            load      = 1'b1;
            rx_data_d = rx_next;
          end
        end else if (shift_edge && bit_cnt_q != 3'd0) begin
          // bit_cnt==0 marks the cpha=1 first edge or the edge after the 8th sample.
          tx_sr_d = tx_shifted;
        end
      end
      FLUSH: begin
        if (bit_cnt_q != 3'd0) frame_err_d = 1'b1;
        bit_cnt_d = 3'd0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (byte_done) begin
      if (rx_ready_q && !rx_reg_re) rx_err_d = 1'b1;
      rx_ready_d = 1'b1;
    end

    // Reload takes the old holding contents; a same-cycle write is kept for the next reload.
    if (load) begin
      if (empty_q) begin
        tx_sr_d    = 8'h00;
        underrun_d = 1'b1;
      end else begin
        tx_sr_d = hold_q;
      end
      empty_d = 1'b1;
    end
    if (tx_reg_we) begin
      hold_d  = tx_data_reg;
      empty_d = 1'b0;
    end
  end

  always_ff @(posedge sysclk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      sck_sync_q  <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_d1_q    <= 1'b0;
      ss_d1_q     <= 1'b1;
      tx_sr_q     <= 8'h00;
      rx_sr_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      hold_q      <= 8'h00;
      empty_q     <= 1'b1;
      rx_data_q   <= 8'h00;
      rx_ready_q  <= 1'b0;
      rx_err_q    <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= sck_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_d1_q    <= sck_d1_d;
      ss_d1_q     <= ss_d1_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_q      <= hold_d;
      empty_q     <= empty_d;
      rx_data_q   <= rx_data_d;
      rx_ready_q  <= rx_ready_d;
      rx_err_q    <= rx_err_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
    end
  end

  assign miso          = miso_q;
  assign miso_oe       = (state_q == ACTIVE);
  assign busy          = (state_q != IDLE);
  assign tx_reg_empty  = empty_q;
  assign rx_data_reg   = rx_data_q;
  assign rx_data_ready = rx_ready_q;
  assign rx_error      = rx_err_q;
  assign tx_underrun   = underrun_q;
  assign frame_error   = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-banged SPI master drives frames; received bytes are checked
// by a monitor against an expected-byte queue, miso bytes and flags are checked inline.
`timescale 1ns/1ps
module tb_spi_slave;

  logic       sysclk = 1'b0;
  logic       nreset;
  logic       enable;
  logic       cpol;
  logic       cpha;
  logic       sck;
  logic       ss;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data_reg;
  logic       tx_reg_we;
  logic       tx_reg_empty;
  logic [7:0] rx_data_reg;
  logic       rx_data_ready;
  logic       rx_reg_re;
  logic       clear_error;
  logic       rx_error;
  logic       tx_underrun;
  logic       frame_error;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       mon_ready_q = 1'b0;
  logic [7:0] mon_data_q  = 8'h00;

  spi_slave #(.SYNC_STAGES(2)) dut (
    .sysclk        (sysclk),
    .nreset        (nreset),
    .enable        (enable),
    .cpol          (cpol),
    .cpha          (cpha),
    .sck           (sck),
    .ss            (ss),
    .mosi          (mosi),
    .miso          (miso),
    .miso_oe       (miso_oe),
    .tx_data_reg   (tx_data_reg),
    .tx_reg_we     (tx_reg_we),
    .tx_reg_empty  (tx_reg_empty),
    .rx_data_reg   (rx_data_reg),
    .rx_data_ready (rx_data_ready),
    .rx_reg_re     (rx_reg_re),
    .clear_error   (clear_error),
    .rx_error      (rx_error),
    .tx_underrun   (tx_underrun),
    .frame_error   (frame_error),
    .busy          (busy)
  );

  // Clock and watchdog
  always #5 sysclk = ~sysclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a received byte is presented when ready rises or the data changes while ready.
  always @(negedge sysclk) begin
    logic [7:0] exp_v;
    if (nreset && rx_data_ready && (!mon_ready_q || rx_data_reg != mon_data_q)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected actual=0x%0h required=none", rx_data_reg);
      end else begin
        exp_v = exp_q.pop_front();
        check("rx_data", {24'd0, rx_data_reg}, {24'd0, exp_v});
      end
    end
    mon_ready_q = rx_data_ready;
    mon_data_q  = rx_data_reg;
  end

  // Driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic write_tx(input logic [7:0] v);
    tx_data_reg = v;
    tx_reg_we   = 1'b1;
    wait_cyc(1);
    tx_reg_we   = 1'b0;
  endtask

  task automatic read_rx();
    rx_reg_re = 1'b1;
    wait_cyc(1);
    rx_reg_re = 1'b0;
    check("ready_after_read", {31'd0, rx_data_ready}, 32'd0);
  endtask

  task automatic pulse_clear();
    clear_error = 1'b1;
    wait_cyc(1);
    clear_error = 1'b0;
  endtask

  task automatic set_mode(input logic pol, input logic pha);
    cpol = pol;
    cpha = pha;
    sck  = pol;
    wait_cyc(8);
  endtask

  task automatic frame_begin();
    ss = 1'b0;
    wait_cyc(8);
    check("busy_in_frame", {31'd0, busy}, 32'd1);
    check("miso_oe_in_frame", {31'd0, miso_oe}, 32'd1);
  endtask

  task automatic frame_end();
    int n;
    ss = 1'b1;
    n  = 0;
    while (busy && n < 20) begin
      wait_cyc(1);
      n++;
    end
    check("busy_after_ss", {31'd0, busy}, 32'd0);
    check("idle_latency_ok", {31'd0, (n <= 5)}, 32'd1);
    check("miso_oe_after_ss", {31'd0, miso_oe}, 32'd0);
  endtask

  // Shifts nbits of m_byte out MSB first and captures miso at each master sample edge.
  task automatic xfer_byte(input logic [7:0] m_byte, input int nbits, input bit refill,
                           input logic [7:0] refill_val, output logic [7:0] s_byte,
                           output bit stable);
    logic cap;
    s_byte = 8'h00;
    stable = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) mosi = m_byte[3'(7 - i)];
      wait_cyc(8);
      cap = miso;
      sck = ~cpol;
      if (cpha) mosi = m_byte[3'(7 - i)];
      else s_byte = {s_byte[6:0], cap};
      wait_cyc(2);
      if (!cpha && miso !== cap) stable = 1'b0;
      wait_cyc(6);
      cap = miso;
      sck = cpol;
      if (cpha) s_byte = {s_byte[6:0], cap};
      wait_cyc(2);
      if (cpha && miso !== cap) stable = 1'b0;
      if (refill && i == 3) begin
        write_tx(refill_val);
        wait_cyc(5);
      end else begin
        wait_cyc(6);
      end
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    check("rst_tx_reg_empty", {31'd0, tx_reg_empty}, 32'd1);
    check("rst_rx_data_reg", {24'd0, rx_data_reg}, 32'd0);
    check("rst_flags", {27'd0, rx_data_ready, rx_error, tx_underrun, frame_error, busy}, 32'd0);
  endtask

  task automatic one_frame(input logic [7:0] slave_tx, input logic [7:0] master_tx);
    logic [7:0] got;
    bit         stable;
    write_tx(slave_tx);
    check("tx_empty_after_write", {31'd0, tx_reg_empty}, 32'd0);
    exp_q.push_back(master_tx);
    frame_begin();
    xfer_byte(master_tx, 8, 1'b1, 8'h00, got, stable);
    frame_end();
    check("miso_byte", {24'd0, got}, {24'd0, slave_tx});
    check("miso_stable", {31'd0, stable}, 32'd1);
    check("ready_after_frame", {31'd0, rx_data_ready}, 32'd1);
    check("tx_empty_after_frame", {31'd0, tx_reg_empty}, 32'd1);
    check("flags_after_frame", {29'd0, rx_error, tx_underrun, frame_error}, 32'd0);
  endtask

  initial begin
    logic [7:0] got;
    bit         stable;

    nreset = 1'b0; enable = 1'b1; cpol = 1'b0; cpha = 1'b0;
    sck = 1'b0; ss = 1'b1; mosi = 1'b0;
    tx_data_reg = 8'h00; tx_reg_we = 1'b0; rx_reg_re = 1'b0; clear_error = 1'b0;
    wait_cyc(3);
    check_reset_outputs();
    nreset = 1'b1;
    wait_cyc(4);
    check_reset_outputs();

    // Mode 0 single byte
    one_frame(8'hA5, 8'h3C);
    check("rx_reg_mode0", {24'd0, rx_data_reg}, 32'h3C);
    read_rx();

    // Modes 1..3
    for (int m = 1; m < 4; m++) begin
      set_mode(m[1], m[0]);
      one_frame(8'h81, 8'h7E);
      read_rx();
    end
    set_mode(1'b0, 1'b0);

    // Back-to-back bytes, no host read in between
    write_tx(8'h11);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hC3);
    frame_begin();
    xfer_byte(8'h5A, 8, 1'b1, 8'h22, got, stable);
    check("b2b_miso_first", {24'd0, got}, 32'h11);
    xfer_byte(8'hC3, 8, 1'b1, 8'h00, got, stable);
    check("b2b_miso_second", {24'd0, got}, 32'h22);
    frame_end();
    check("b2b_rx_error", {31'd0, rx_error}, 32'd1);
    check("b2b_rx_data", {24'd0, rx_data_reg}, 32'hC3);
    check("b2b_underrun", {31'd0, tx_underrun}, 32'd0);
    pulse_clear();
    check("b2b_rx_error_cleared", {31'd0, rx_error}, 32'd0);
    read_rx();

    // Underrun: frame starts with empty holding register
    check("ur_empty_before", {31'd0, tx_reg_empty}, 32'd1);
    exp_q.push_back(8'h96);
    frame_begin();
    check("ur_flag_at_start", {31'd0, tx_underrun}, 32'd1);
    xfer_byte(8'h96, 8, 1'b0, 8'h00, got, stable);
    frame_end();
    check("ur_miso_byte", {24'd0, got}, 32'h00);
    pulse_clear();
    check("ur_flag_cleared", {31'd0, tx_underrun}, 32'd0);
    read_rx();

    // Frame error: ss raised after 5 bits, with an unread byte pending
    write_tx(8'hF0);
    exp_q.push_back(8'h69);
    frame_begin();
    xfer_byte(8'h69, 8, 1'b1, 8'h00, got, stable);
    frame_end();
    write_tx(8'h0F);
    frame_begin();
    xfer_byte(8'hFF, 5, 1'b0, 8'h00, got, stable);
    frame_end();
    check("fe_frame_error", {31'd0, frame_error}, 32'd1);
    check("fe_ready_kept", {31'd0, rx_data_ready}, 32'd1);
    check("fe_rx_data_kept", {24'd0, rx_data_reg}, 32'h69);
    check("fe_rx_error", {31'd0, rx_error}, 32'd0);
    pulse_clear();
    check("fe_cleared", {31'd0, frame_error}, 32'd0);
    read_rx();

    // Reset mid-byte, then a clean frame
    write_tx(8'h3C);
    frame_begin();
    xfer_byte(8'h55, 3, 1'b0, 8'h00, got, stable);
    nreset = 1'b0;
    wait_cyc(2);
    check_reset_outputs();
    ss = 1'b1; sck = cpol; mosi = 1'b0;
    wait_cyc(3);
    nreset = 1'b1;
    wait_cyc(5);
    one_frame(8'hC5, 8'hB7);
    check("post_reset_rx", {24'd0, rx_data_reg}, 32'hB7);
    read_rx();

    wait_cyc(4);
    check("rx_queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
